// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory unit: access sizes, FSM states
// and the lane-bit count derived from the data-bus width.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic int unsigned lane_bits(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte strobes and lane placement for stores,
// lane extraction plus sign/zero extension for loads.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 64,
  localparam int unsigned NB         = DATA_WIDTH / 8,
  localparam int unsigned LB         = lane_bits(DATA_WIDTH)
) (
  input  logic [LB-1:0]         lane_i,
  input  size_e                 size_i,
  input  logic                  unsigned_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] rword_i,
  output logic [NB-1:0]         wstrb_o,
  output logic [DATA_WIDTH-1:0] wlanes_o,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [NB-1:0]         base_strb;
  logic [DATA_WIDTH-1:0] keep_mask;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  sign_bit;

  assign shifted = rword_i >> {lane_i, 3'b000};

  always_comb begin
    base_strb = '1;
    keep_mask = '1;
    sign_bit  = 1'b0;
    case (size_i)
      SZ_B: begin
        base_strb = NB'(1);
        keep_mask = DATA_WIDTH'(8'hFF);
        sign_bit  = shifted[7];
      end
      SZ_H: begin
        base_strb = NB'(3);
        keep_mask = DATA_WIDTH'(16'hFFFF);
        sign_bit  = shifted[15];
      end
      SZ_W: begin
        base_strb = NB'(4'hF);
        keep_mask = DATA_WIDTH'(32'hFFFF_FFFF);
        sign_bit  = shifted[31];
      end
      default: begin
        base_strb = '1;
        keep_mask = '1;
        sign_bit  = 1'b0;
      end
    endcase
  end

  assign wstrb_o  = base_strb << lane_i;
  assign wlanes_o = wdata_i << {lane_i, 3'b000};

  // A full-width access keeps every bit, so ~keep_mask is zero and no extension occurs.
  assign rdata_o = (shifted & keep_mask) |
                   ((sign_bit && !unsigned_i) ? ~keep_mask : '0);

endmodule

// File: rtl/data_mem_unit.sv
// Data memory for the load/store path: one outstanding request, configurable
// latency, byte-lane stores, extending loads and access error reporting.
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned LB = lane_bits(DATA_WIDTH);
  localparam int unsigned IW = $clog2(DEPTH_WORDS);
  localparam logic [1:0]  CNT_INIT = 2'(LATENCY - 1);

  state_e                state_q;
  logic [1:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  size_e                 size_q;
  logic                  uns_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  ready_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [IW-1:0]         mem_idx;
  logic                  misalign;
  logic                  out_of_range;
  logic                  bad_size;
  logic                  acc_err;
  logic                  access_now;
  logic                  do_write;
  logic [NB-1:0]         wstrb;
  logic [DATA_WIDTH-1:0] wlanes;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] rdata_d;

  // Error checks run on the latched request so they are stable through BUSY.
  assign word_idx     = addr_q >> LB;
  assign mem_idx      = word_idx[IW-1:0];
  assign out_of_range = word_idx >= ADDR_WIDTH'(DEPTH_WORDS);
  assign bad_size     = (DATA_WIDTH == 32) && (size_q == SZ_D);

  always_comb begin
    misalign = 1'b0;
    case (size_q)
      SZ_H:    misalign = addr_q[0];
      SZ_W:    misalign = |addr_q[1:0];
      SZ_D:    misalign = |addr_q[2:0];
      default: misalign = 1'b0;
    endcase
  end

  assign acc_err    = misalign || out_of_range || bad_size;
  assign access_now = (state_q == BUSY) && (cnt_q == 2'd0);
  assign do_write   = access_now && we_q && !acc_err;
  assign rdata_d    = (acc_err || we_q) ? '0 : load_data;

  dmem_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .lane_i     (addr_q[LB-1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .rword_i    (mem_q[mem_idx]),
    .wstrb_o    (wstrb),
    .wlanes_o   (wlanes),
    .rdata_o    (load_data)
  );

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb[b]) mem_q[mem_idx][b*8 +: 8] <= wlanes[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && ready_q) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            size_q  <= size_e'(req_size);
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
            cnt_q   <= CNT_INIT;
            ready_q <= 1'b0;
            state_q <= BUSY;
          end else begin
            ready_q <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt_q == 2'd0) begin
            valid_q <= 1'b1;
            rdata_q <= rdata_d;
            err_q   <= acc_err;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit: directed vector table, randomized
// traffic against a byte-level reference model, and multi-cycle corner cases.
module tb_data_mem_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [63:0] resp_rdata;

  logic        b_req_valid = 1'b0, b_req_we = 1'b0, b_req_unsigned = 1'b0, b_resp_ready = 1'b0;
  logic [1:0]  b_req_size = 2'd0;
  logic [63:0] b_req_addr = '0, b_req_wdata = '0;
  logic        b_req_ready, b_resp_valid, b_resp_err;
  logic [63:0] b_resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ref_mem [longint unsigned];

  always #5 clk = ~clk;

  data_mem_unit #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .DEPTH_WORDS(1024), .LATENCY(1)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_unit #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .DEPTH_WORDS(1024), .LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr), .req_we(b_req_we),
    .req_size(b_req_size), .req_unsigned(b_req_unsigned), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // Reference: memory as individual bytes; value built by summing shifted bytes.
  task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wd,
                       output logic [63:0] rd, output logic er);
    longint unsigned n = 64'd1 << sz;
    logic [63:0] v = '0;
    er = ((addr % n) != 0) || ((addr / 8) >= 1024);
    rd = '0;
    if (!er) begin
      if (we) begin
        for (longint unsigned i = 0; i < n; i++) ref_mem[addr + i] = wd[8*i +: 8];
      end else begin
        for (longint unsigned i = 0; i < n; i++) v = v + (64'(ref_mem[addr + i]) << (8 * i));
        if (!uns && n < 8 && ((v >> (8 * n - 1)) & 64'd1) != 0)
          v = v | ~((64'd1 << (8 * n)) - 1);
        rd = v;
      end
    end
  endtask

  task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [63:0] addr, input logic [63:0] wd,
                     output logic [63:0] rd, output logic er, output int lat);
    int guard = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic txn3(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [63:0] addr, input logic [63:0] wd,
                      output logic [63:0] rd, output logic er, output int lat);
    int guard = 0;
    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = we; b_req_size = sz; b_req_unsigned = uns;
    b_req_addr = addr; b_req_wdata = wd;
    while (!b_req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 b_req_valid = 1'b0;
    lat = 0;
    while (!b_resp_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    rd = b_resp_rdata;
    er = b_resp_err;
    b_resp_ready = 1'b1;
    @(posedge clk);
    #1 b_resp_ready = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [63:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[18];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd, exp_rd, v;
    logic        er, exp_er;
    int          lat;
    logic [63:0] a;

    vecs[0]  = '{1'b1, 2'd3, 1'b0, 64'h40,   64'h1122334455667788, 64'h0, 1'b0};
    vecs[1]  = '{1'b0, 2'd3, 1'b0, 64'h40,   64'h0, 64'h1122334455667788, 1'b0};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 64'h43,   64'h80, 64'h0, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 64'h43,   64'h0, 64'hFFFFFFFFFFFFFF80, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 64'h43,   64'h0, 64'h80, 1'b0};
    vecs[5]  = '{1'b0, 2'd3, 1'b0, 64'h40,   64'h0, 64'h1122334480667788, 1'b0};
    vecs[6]  = '{1'b0, 2'd2, 1'b0, 64'h42,   64'h0, 64'h0, 1'b1};
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 64'h41,   64'hBEEF, 64'h0, 1'b1};
    vecs[8]  = '{1'b0, 2'd3, 1'b0, 64'h40,   64'h0, 64'h1122334480667788, 1'b0};
    vecs[9]  = '{1'b0, 2'd3, 1'b0, 64'h2000, 64'h0, 64'h0, 1'b1};
    vecs[10] = '{1'b0, 2'd1, 1'b0, 64'h46,   64'h0, 64'h1122, 1'b0};
    vecs[11] = '{1'b0, 2'd2, 1'b0, 64'h40,   64'h0, 64'hFFFFFFFF80667788, 1'b0};
    vecs[12] = '{1'b0, 2'd2, 1'b1, 64'h44,   64'h0, 64'h11223344, 1'b0};
    vecs[13] = '{1'b0, 2'd1, 1'b0, 64'h42,   64'h0, 64'hFFFFFFFFFFFF8066, 1'b0};
    vecs[14] = '{1'b1, 2'd3, 1'b0, 64'h41,   64'h5555, 64'h0, 1'b1};
    vecs[15] = '{1'b0, 2'd0, 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'h0, 64'h0, 1'b1};
    vecs[16] = '{1'b1, 2'd3, 1'b0, 64'h2040, 64'hAAAAAAAAAAAAAAAA, 64'h0, 1'b1};
    vecs[17] = '{1'b0, 2'd3, 1'b0, 64'h40,   64'h0, 64'h1122334480667788, 1'b0};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst req_ready", 64'(req_ready), 64'd0);
    check("rst resp_valid", 64'(resp_valid), 64'd0);
    check("rst resp_rdata", resp_rdata, 64'd0);
    check("rst resp_err", 64'(resp_err), 64'd0);
    check("rst b_req_ready", 64'(b_req_ready), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post-rst req_ready", 64'(req_ready), 64'd1);
    check("post-rst b_req_ready", 64'(b_req_ready), 64'd1);

    // Directed table
    for (int i = 0; i < 18; i++) begin
      txn(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd, rd, er, lat);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d err", i), 64'(er), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d latency", i), 64'(lat), 64'd1);
      check($sformatf("vec%0d ready after handshake", i), 64'(req_ready), 64'd1);
    end

    // Fill a known region (and the last in-range word) through the model
    for (int w = 0; w <= 32; w++) begin
      a = (w == 32) ? 64'h1FF8 : 64'(w * 8);
      v = {$urandom, $urandom};
      model(1'b1, 2'd3, 1'b0, a, v, exp_rd, exp_er);
      txn(1'b1, 2'd3, 1'b0, a, v, rd, er, lat);
      check($sformatf("fill %h err", a), 64'(er), 64'(exp_er));
    end

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic        we, uns;
      logic [1:0]  sz;
      int          pick;
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      pick = $urandom_range(0, 19);
      if (pick < 15)      a = 64'($urandom_range(0, 255));
      else if (pick < 18) a = 64'h1FF8 + 64'($urandom_range(0, 15));
      else                a = {$urandom, $urandom} | 64'h1_0000_0000;
      v = {$urandom, $urandom};
      model(we, sz, uns, a, v, exp_rd, exp_er);
      txn(we, sz, uns, a, v, rd, er, lat);
      check($sformatf("rand%0d we=%0d sz=%0d a=%h rdata", i, we, sz, a), rd, exp_rd);
      check($sformatf("rand%0d err", i), 64'(er), 64'(exp_er));
      check($sformatf("rand%0d latency", i), 64'(lat), 64'd1);
    end

    // Reset during BUSY aborts the store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
    req_addr = 64'h80; req_wdata = 64'hDEAD;
    check("abort ready before accept", 64'(req_ready), 64'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    req_valid = 1'b0;
    #1;
    check("abort resp_valid", 64'(resp_valid), 64'd0);
    check("abort req_ready", 64'(req_ready), 64'd0);
    check("abort resp_rdata", resp_rdata, 64'd0);
    check("abort resp_err", 64'(resp_err), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort ready after release", 64'(req_ready), 64'd1);
    model(1'b0, 2'd3, 1'b0, 64'h80, 64'h0, exp_rd, exp_er);
    txn(1'b0, 2'd3, 1'b0, 64'h80, 64'h0, rd, er, lat);
    check("abort 0x80 retained", rd, exp_rd);

    // LATENCY=3 with backpressure and a request offered on the handshake cycle
    txn3(1'b1, 2'd3, 1'b0, 64'h10, 64'hCAFEF00D12345678, rd, er, lat);
    check("lat3 store latency", 64'(lat), 64'd3);
    check("lat3 store err", 64'(er), 64'd0);
    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_size = 2'd3; b_req_unsigned = 1'b0;
    b_req_addr = 64'h10;
    check("lat3 ready before accept", 64'(b_req_ready), 64'd1);
    @(posedge clk);
    #1 b_req_valid = 1'b0;
    check("lat3 ready after accept", 64'(b_req_ready), 64'd0);
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("lat3 valid at accept+%0d", c - 1), 64'(b_resp_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    check("lat3 valid at accept+3", 64'(b_resp_valid), 64'd1);
    check("lat3 rdata", b_resp_rdata, 64'hCAFEF00D12345678);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold%0d valid", c), 64'(b_resp_valid), 64'd1);
      check($sformatf("hold%0d rdata", c), b_resp_rdata, 64'hCAFEF00D12345678);
      check($sformatf("hold%0d err", c), 64'(b_resp_err), 64'd0);
      check($sformatf("hold%0d req_ready", c), 64'(b_req_ready), 64'd0);
    end
    @(negedge clk);
    b_resp_ready = 1'b1;
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_size = 2'd2; b_req_unsigned = 1'b1;
    b_req_addr = 64'h14;
    @(posedge clk);
    #1 b_resp_ready = 1'b0;
    check("handshake valid drop", 64'(b_resp_valid), 64'd0);
    check("no forwarding ready", 64'(b_req_ready), 64'd1);
    @(posedge clk);
    #1 b_req_valid = 1'b0;
    check("second accept ready", 64'(b_req_ready), 64'd0);
    lat = 0;
    while (!b_resp_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check("second latency", 64'(lat), 64'd3);
    check("second rdata", b_resp_rdata, 64'hCAFEF00D);
    check("second err", 64'(b_resp_err), 64'd0);
    b_resp_ready = 1'b1;
    @(posedge clk);
    #1 b_resp_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
